// File: rtl/sensor_filter_pkg.sv
// sensor_filter_pkg
//   Shared definitions for the three-channel sensor conditioning stage:
//   default parameter values, the controller state encoding and the
//   accumulator width helper.
//   Optional feature macro used by sensor_filter: SENSOR_FILTER_RAIN_HYST_EN.
package sensor_filter_pkg;

  localparam int DEF_RESOLUTION    = 10;
  localparam int DEF_LOG2_SAMPLES  = 3;
  localparam int DEF_SAMPLE_DIV    = 4;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_RAIN_ON       = 600;
  localparam int DEF_RAIN_OFF      = 400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_t;

  // A window of 2^log2_samples codes of `resolution` bits sums into exactly
  // resolution+log2_samples bits, so this width can never overflow.
  function automatic int acc_width(input int resolution, input int log2_samples);
    return resolution + log2_samples;
  endfunction

endpackage

// File: rtl/sensor_filter_acc.sv
// sensor_filter_acc
//   One boxcar channel: accumulates sample codes and presents the window
//   average that would result if the current sample were the last one.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  synchronous active-high reset
//   clear   in  zero the accumulator on this edge (wins over add)
//   add     in  add `sample` into the accumulator on this edge
//   sample  in  raw channel code
//   avg     out (acc + sample) >> LOG2_SAMPLES, combinational, truncated
module sensor_filter_acc
  import sensor_filter_pkg::*;
#(
  parameter int RESOLUTION   = DEF_RESOLUTION,
  parameter int LOG2_SAMPLES = DEF_LOG2_SAMPLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add,
  input  logic [RESOLUTION-1:0] sample,
  output logic [RESOLUTION-1:0] avg
);

  localparam int ACC_W = acc_width(RESOLUTION, LOG2_SAMPLES);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  assign sum = acc + ACC_W'(sample);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end
  end

  // Dropping the low bits of the full sum is the truncating divide.
  assign avg = RESOLUTION'(sum >> LOG2_SAMPLES);

endmodule

// File: rtl/sensor_filter.sv
// sensor_filter
//   Three-channel conditioning stage (soil, temperature, rain). After every
//   re-enable it discards SETTLE_CYCLES cycles, then takes one sample every
//   SAMPLE_DIV cycles and publishes 2^LOG2_SAMPLES-sample boxcar averages
//   with a one-cycle avg_valid strobe. Windows run back-to-back while
//   sensor_enable stays high; dropping it abandons the partial window.
//   Optional feature macro: SENSOR_FILTER_RAIN_HYST_EN (hysteretic rain_wet);
//   without it rain_wet is tied to 0.
// Ports:
//   clk            in  clock, rising edge
//   reset          in  synchronous active-high reset
//   sensor_enable  in  sampling allowed (low while the pump runs)
//   soil_digital   in  raw soil code
//   dht11_digital  in  raw temperature code
//   rain_digital   in  raw rain code
//   soil_avg       out last completed soil average
//   temp_avg       out last completed temperature average
//   rain_avg       out last completed rain average
//   avg_valid      out one-cycle pulse after the averages update
//   busy           out state is not IDLE
//   rain_wet       out hysteretic rain flag
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | sampling disabled; counters and accumulators held at zero
// SETTLE | sensors powering up, readings discarded for SETTLE_CYCLES
// ACCUM  | sampling every SAMPLE_DIV cycles, publishing each full window
module sensor_filter
  import sensor_filter_pkg::*;
#(
  parameter int RESOLUTION    = DEF_RESOLUTION,
  parameter int LOG2_SAMPLES  = DEF_LOG2_SAMPLES,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RAIN_ON       = DEF_RAIN_ON,
  parameter int RAIN_OFF      = DEF_RAIN_OFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sensor_enable,
  input  logic [RESOLUTION-1:0] soil_digital,
  input  logic [RESOLUTION-1:0] dht11_digital,
  input  logic [RESOLUTION-1:0] rain_digital,
  output logic [RESOLUTION-1:0] soil_avg,
  output logic [RESOLUTION-1:0] temp_avg,
  output logic [RESOLUTION-1:0] rain_avg,
  output logic                  avg_valid,
  output logic                  busy,
  output logic                  rain_wet
);

  // Settle and divider timers count down to zero; the reload values are
  // chosen so the terminal edge lands SETTLE_CYCLES / SAMPLE_DIV edges
  // after the load.
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD    = DIV_W'(SAMPLE_DIV - 1);

  state_t state, state_nxt;

  logic [SET_W-1:0]        settle_cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic [LOG2_SAMPLES-1:0] samp_cnt;

  logic sample_stb;
  logic final_stb;
  logic acc_clr;
  logic acc_add;

  logic [RESOLUTION-1:0] soil_nxt;
  logic [RESOLUTION-1:0] temp_nxt;
  logic [RESOLUTION-1:0] rain_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sample_stb = 1'b0;
    final_stb  = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_clr = 1'b1;
        if (sensor_enable) begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!sensor_enable) begin
          state_nxt = ST_IDLE;
          acc_clr   = 1'b1;
        end else if (settle_cnt == '0) begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // A disable on the final-sample edge suppresses the publish.
        if (!sensor_enable) begin
          state_nxt = ST_IDLE;
          acc_clr   = 1'b1;
        end else if (div_cnt == '0) begin
          sample_stb = 1'b1;
          final_stb  = &samp_cnt;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        acc_clr   = 1'b1;
      end
    endcase
  end

  // On the final sample the accumulators clear instead of adding; the
  // published average already includes that sample combinationally.
  assign acc_add = sample_stb & ~final_stb;

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
      div_cnt    <= '0;
      samp_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          settle_cnt <= sensor_enable ? SETTLE_LOAD : '0;
          div_cnt    <= '0;
          samp_cnt   <= '0;
        end
        ST_SETTLE: begin
          if (!sensor_enable) begin
            settle_cnt <= '0;
            div_cnt    <= '0;
            samp_cnt   <= '0;
          end else if (settle_cnt == '0) begin
            div_cnt  <= DIV_LOAD;
            samp_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_ACCUM: begin
          if (!sensor_enable) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
          end else if (div_cnt == '0) begin
            div_cnt  <= DIV_LOAD;
            // Wraps to zero after the final sample, starting the next window.
            samp_cnt <= samp_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: begin
          settle_cnt <= '0;
          div_cnt    <= '0;
          samp_cnt   <= '0;
        end
      endcase
    end
  end

  sensor_filter_acc #(
    .RESOLUTION   (RESOLUTION),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_acc_soil (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clr | final_stb),
    .add    (acc_add),
    .sample (soil_digital),
    .avg    (soil_nxt)
  );

  sensor_filter_acc #(
    .RESOLUTION   (RESOLUTION),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_acc_temp (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clr | final_stb),
    .add    (acc_add),
    .sample (dht11_digital),
    .avg    (temp_nxt)
  );

  sensor_filter_acc #(
    .RESOLUTION   (RESOLUTION),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_acc_rain (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clr | final_stb),
    .add    (acc_add),
    .sample (rain_digital),
    .avg    (rain_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      soil_avg  <= '0;
      temp_avg  <= '0;
      rain_avg  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= final_stb;
      if (final_stb) begin
        soil_avg <= soil_nxt;
        temp_avg <= temp_nxt;
        rain_avg <= rain_nxt;
      end
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef SENSOR_FILTER_RAIN_HYST_EN
  localparam logic [RESOLUTION-1:0] RAIN_ON_C  = RESOLUTION'(RAIN_ON);
  localparam logic [RESOLUTION-1:0] RAIN_OFF_C = RESOLUTION'(RAIN_OFF);

  // Judged on the fresh average, on the same edge it is published.
  always_ff @(posedge clk) begin
    if (reset) begin
      rain_wet <= 1'b0;
    end else if (final_stb) begin
      if (rain_nxt >= RAIN_ON_C) begin
        rain_wet <= 1'b1;
      end else if (rain_nxt <= RAIN_OFF_C) begin
        rain_wet <= 1'b0;
      end
    end
  end
`else
  // Thresholds stay on the parameter list so both builds share one
  // interface; the expression is constant zero.
  assign rain_wet = 1'b0 & (RAIN_OFF < RAIN_ON);
`endif

endmodule

// File: tb/tb_sensor_filter.sv
// tb_sensor_filter
//   Self-checking bench for sensor_filter. A reference model counts edges
//   since entry and collects sample values in queues, then averages with
//   plain integer division; outputs are compared every cycle.
//   Honors SENSOR_FILTER_RAIN_HYST_EN for the expected rain_wet.
module tb_sensor_filter;

  localparam int RES    = 10;
  localparam int L2S    = 3;
  localparam int NS     = 1 << L2S;
  localparam int DIV    = 4;
  localparam int SETTLE = 8;
  localparam int R_ON   = 600;
  localparam int R_OFF  = 400;
  localparam int FIRST_VALID = SETTLE + NS * DIV;

`ifdef SENSOR_FILTER_RAIN_HYST_EN
  localparam int HYST_ON = 1;
`else
  localparam int HYST_ON = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           sensor_enable;
  logic [RES-1:0] soil_digital;
  logic [RES-1:0] dht11_digital;
  logic [RES-1:0] rain_digital;
  logic [RES-1:0] soil_avg;
  logic [RES-1:0] temp_avg;
  logic [RES-1:0] rain_avg;
  logic           avg_valid;
  logic           busy;
  logic           rain_wet;

  always #5 clk = ~clk;

  sensor_filter #(
    .RESOLUTION    (RES),
    .LOG2_SAMPLES  (L2S),
    .SAMPLE_DIV    (DIV),
    .SETTLE_CYCLES (SETTLE),
    .RAIN_ON       (R_ON),
    .RAIN_OFF      (R_OFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_enable (sensor_enable),
    .soil_digital  (soil_digital),
    .dht11_digital (dht11_digital),
    .rain_digital  (rain_digital),
    .soil_avg      (soil_avg),
    .temp_avg      (temp_avg),
    .rain_avg      (rain_avg),
    .avg_valid     (avg_valid),
    .busy          (busy),
    .rain_wet      (rain_wet)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_win    = 0;
  int q_soil[$];
  int q_temp[$];
  int q_rain[$];
  int e_soil  = 0;
  int e_temp  = 0;
  int e_rain  = 0;
  int e_valid = 0;
  int e_wet   = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int q_avg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / NS;
  endfunction

  // One rising edge of the specified behaviour.
  task automatic model_edge(input bit rst, input bit en, input int s, input int t, input int r);
    e_valid = 0;
    if (rst) begin
      m_active = 1'b0;
      m_win = 0;
      q_soil.delete(); q_temp.delete(); q_rain.delete();
      e_soil = 0; e_temp = 0; e_rain = 0; e_wet = 0;
    end else if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_n = 0;
        m_win = 0;
      end
    end else if (!en) begin
      m_active = 1'b0;
      q_soil.delete(); q_temp.delete(); q_rain.delete();
    end else begin
      m_n++;
      if (m_n >= SETTLE + DIV && (m_n - SETTLE) % DIV == 0) begin
        q_soil.push_back(s); q_temp.push_back(t); q_rain.push_back(r);
        if (q_soil.size() == NS) begin
          e_soil = q_avg(q_soil);
          e_temp = q_avg(q_temp);
          e_rain = q_avg(q_rain);
          e_valid = 1;
          m_win++;
          if (HYST_ON != 0) begin
            if (e_rain >= R_ON) e_wet = 1;
            else if (e_rain <= R_OFF) e_wet = 0;
          end
          q_soil.delete(); q_temp.delete(); q_rain.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input int s, input int t, input int r);
    @(negedge clk);
    reset         = rst;
    sensor_enable = en;
    soil_digital  = RES'(s);
    dht11_digital = RES'(t);
    rain_digital  = RES'(r);
    model_edge(rst, en, s, t, r);
    @(posedge clk);
    #1;
    chk_eq("soil_avg",  int'(soil_avg),  e_soil);
    chk_eq("temp_avg",  int'(temp_avg),  e_temp);
    chk_eq("rain_avg",  int'(rain_avg),  e_rain);
    chk_eq("avg_valid", int'(avg_valid), e_valid);
    chk_eq("busy",      int'(busy),      int'(m_active));
    chk_eq("rain_wet",  int'(rain_wet),  e_wet);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 11, 22, 33);
  endtask

  initial begin
    int first;
    int r;
    reset = 1'b1; sensor_enable = 1'b0;
    soil_digital = '0; dht11_digital = '0; rain_digital = '0;

    cycle(1'b1, 1'b0, 0, 0, 0);
    cycle(1'b1, 1'b1, 0, 0, 0);
    chk_eq("reset_busy", int'(busy), 0);
    chk_eq("reset_valid", int'(avg_valid), 0);
    idle(2);

    // Constant inputs: single pulse at E40, averages equal the inputs.
    first = -1;
    for (int i = 0; i < 45; i++) begin
      cycle(1'b0, 1'b1, 512, 300, 700);
      if (avg_valid && first < 0) first = i;
      if (i == 0) chk_eq("busy_at_e0", int'(busy), 1);
    end
    chk_eq("first_valid_edge", first, FIRST_VALID);
    chk_eq("const_soil", int'(soil_avg), 512);
    chk_eq("const_temp", int'(temp_avg), 300);
    chk_eq("const_rain", int'(rain_avg), 700);
    chk_eq("const_wet", int'(rain_wet), HYST_ON);
    idle(2);

    // Ramp 0..7 on soil: 28 >> 3 = 3.
    for (int i = 0; i < FIRST_VALID + 1; i++)
      cycle(1'b0, 1'b1, q_soil.size(), 5, 1023);
    chk_eq("ramp_soil", int'(soil_avg), 3);
    idle(2);

    // Full-scale codes must not overflow.
    for (int i = 0; i < FIRST_VALID + 1; i++) cycle(1'b0, 1'b1, 1023, 1023, 1023);
    chk_eq("max_soil", int'(soil_avg), 1023);
    chk_eq("max_temp", int'(temp_avg), 1023);
    chk_eq("max_rain", int'(rain_avg), 1023);
    idle(2);

    // Disable at E30: no publish, outputs hold, full restart afterwards.
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 100, 200, 300);
    cycle(1'b0, 1'b0, 100, 200, 300);
    chk_eq("drop_busy", int'(busy), 0);
    idle(4);
    chk_eq("hold_soil", int'(soil_avg), 1023);
    first = -1;
    for (int i = 0; i < FIRST_VALID + 1; i++) begin
      cycle(1'b0, 1'b1, 100, 200, 300);
      if (avg_valid && first < 0) first = i;
    end
    chk_eq("reentry_first_valid", first, FIRST_VALID);
    idle(2);

    // Hysteresis: 700 -> 500 (hold) -> 400 (clear).
    for (int i = 0; i < FIRST_VALID + 1 + 2 * NS * DIV; i++) begin
      r = (m_win == 0) ? 700 : ((m_win == 1) ? 500 : 400);
      cycle(1'b0, 1'b1, 321, 123, r);
      if (i == FIRST_VALID) chk_eq("wet_after_700", int'(rain_wet), HYST_ON);
      if (i == FIRST_VALID + NS * DIV) chk_eq("wet_after_500", int'(rain_wet), HYST_ON);
    end
    chk_eq("wet_after_400", int'(rain_wet), 0);
    chk_eq("rain_avg_400", int'(rain_avg), 400);

    // Reset at E20 of a fresh entry, released with enable still high.
    idle(2);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 50, 60, 900);
    cycle(1'b1, 1'b1, 50, 60, 900);
    chk_eq("rst_soil", int'(soil_avg), 0);
    chk_eq("rst_busy", int'(busy), 0);
    first = -1;
    for (int i = 0; i < FIRST_VALID + 1; i++) begin
      cycle(1'b0, 1'b1, 50, 60, 900);
      if (avg_valid && first < 0) first = i;
    end
    chk_eq("post_reset_first_valid", first, FIRST_VALID);

    // Random traffic with occasional disables and rare resets.
    for (int i = 0; i < 1500; i++) begin
      bit en;
      bit rst;
      int s, t;
      en  = ($urandom_range(0, 999) < 990);
      rst = ($urandom_range(0, 999) == 0);
      s = ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 1023));
      t = int'($urandom_range(0, 1023));
      r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(300, 700)) : int'($urandom_range(0, 1023));
      cycle(rst, en, s, t, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
